// File: rtl/stack_calc_core.sv
// Push-down calculator core: downward-growing stack in a single-port
// synchronous RAM, driven by a small multi-cycle command FSM.
module stack_calc_core #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 7
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  input  logic [2:0]        cmd,
  input  logic [DATA_W-1:0] din,
  output logic              cmd_ready,
  output logic              done,
  output logic [DATA_W-1:0] dvr,
  output logic [ADDR_W-1:0] dar,
  output logic              empty,
  output logic              full,
  output logic              err
);
  localparam int DEPTH = 2**ADDR_W;
  localparam logic [ADDR_W:0] CNT_FULL = (ADDR_W+1)'(DEPTH);
  localparam logic [2:0] OP_PUSH = 3'd0;
  localparam logic [2:0] OP_POP  = 3'd1;
  localparam logic [2:0] OP_ADD  = 3'd2;
  localparam logic [2:0] OP_SUB  = 3'd3;
  localparam logic [2:0] OP_TOP  = 3'd4;
  localparam logic [2:0] OP_INC  = 3'd5;
  localparam logic [2:0] OP_DEC  = 3'd6;
  localparam logic [2:0] OP_CLR  = 3'd7;

  typedef enum logic [2:0] {
    IDLE, PUSH_WR, POP_RD, OP_RD1,
    OP_RD2, OP_WR, ADR_RD, DONE
  } state_t;

  state_t r_state, w_next;
  logic [ADDR_W:0]   r_count;
  logic [ADDR_W-1:0] r_dar;
  logic [DATA_W-1:0] r_dvr, r_din, r_op1, r_res, r_rdata;
  logic [2:0]        r_op;
  logic              r_err, r_done, r_phase;
  logic [DATA_W-1:0] r_mem [DEPTH];

  logic              w_accept, w_bad, w_we, w_full, w_empty;
  logic [ADDR_W-1:0] w_cnt_lo, w_top, w_second, w_push_a, w_addr;
  logic [DATA_W-1:0] w_wdata;

  assign w_full    = (r_count == CNT_FULL);
  assign w_empty   = (r_count == '0);
  assign cmd_ready = (r_state == IDLE) && !rst;
  assign w_accept  = cmd_valid && cmd_ready;
  assign w_cnt_lo  = r_count[ADDR_W-1:0];
  assign w_top     = '0 - w_cnt_lo;
  assign w_second  = w_top + 1'b1;
  assign w_push_a  = ~w_cnt_lo;

  assign w_bad = (cmd == OP_PUSH && w_full)
              || (cmd == OP_POP && w_empty)
              || ((cmd == OP_ADD || cmd == OP_SUB)
                  && r_count < (ADDR_W+1)'(2));

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE: begin
        if (w_accept) begin
          if (w_bad || cmd == OP_CLR) begin
            w_next = DONE;
          end else begin
            unique case (1'b1)
              cmd == OP_PUSH:                 w_next = PUSH_WR;
              cmd == OP_ADD || cmd == OP_SUB: w_next = OP_RD1;
              default:                        w_next = POP_RD;
            endcase
          end
        end
      end
      PUSH_WR: w_next = DONE;
      POP_RD:  w_next = ADR_RD;
      ADR_RD:  w_next = DONE;
      OP_RD1:  w_next = OP_RD2;
      OP_RD2:  w_next = r_phase ? OP_WR : OP_RD2;
      OP_WR:   w_next = DONE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    w_addr = r_dar;
    case (r_state)
      PUSH_WR:       w_addr = w_push_a;
      OP_RD1:        w_addr = w_top;
      OP_RD2, OP_WR: w_addr = w_second;
      default:       w_addr = r_dar;
    endcase
  end

  // Reset blocks the write so an aborted command never touches RAM.
  assign w_we    = !rst && (r_state == PUSH_WR || r_state == OP_WR);
  assign w_wdata = (r_state == OP_WR) ? r_res : r_din;

  always_ff @(posedge clk) begin
    if (w_we) r_mem[w_addr] <= w_wdata;
    r_rdata <= r_mem[w_addr];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_count <= '0;
      r_dar   <= '0;
      r_dvr   <= '0;
      r_err   <= 1'b0;
      r_done  <= 1'b0;
      r_phase <= 1'b0;
    end else begin
      r_state <= w_next;
      r_done  <= (r_state == DONE);
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_op    <= cmd;
            r_din   <= din;
            r_phase <= 1'b0;
            if (w_bad) begin
              r_err <= 1'b1;
            end else begin
              case (cmd)
                OP_POP: begin
                  r_count <= r_count - 1'b1;
                  r_dar   <= w_second;
                end
                OP_TOP: r_dar <= w_top;
                OP_INC: r_dar <= r_dar + 1'b1;
                OP_DEC: r_dar <= r_dar - 1'b1;
                OP_CLR: begin
                  r_count <= '0;
                  r_dar   <= '0;
                  r_dvr   <= '0;
                  r_err   <= 1'b0;
                end
                default: ;
              endcase
            end
          end
        end
        PUSH_WR: begin
          r_count <= r_count + 1'b1;
          r_dar   <= w_push_a;
          r_dvr   <= r_din;
        end
        // First pass latches the top entry, second pass forms the result.
        OP_RD2: begin
          r_phase <= 1'b1;
          if (!r_phase) r_op1 <= r_rdata;
          else if (r_op == OP_ADD) r_res <= r_rdata + r_op1;
          else r_res <= r_rdata - r_op1;
        end
        OP_WR: begin
          r_count <= r_count - 1'b1;
          r_dar   <= w_second;
          r_dvr   <= r_res;
        end
        ADR_RD: begin
          if ((r_op == OP_POP || r_op == OP_TOP) && w_empty)
            r_dvr <= '0;
          else
            r_dvr <= r_rdata;
        end
        default: ;
      endcase
    end
  end

  assign done  = r_done;
  assign dvr   = r_dvr;
  assign dar   = r_dar;
  assign empty = w_empty;
  assign full  = w_full;
  assign err   = r_err;
endmodule

// File: tb/tb_stack_calc_core.sv
// Bench for stack_calc_core: directed scenarios plus random
// command streams against an array-based stack model.
module tb_stack_calc_core;
  localparam int DW = 8;
  localparam int AW = 7;
  localparam int DEPTH = 128;

  logic clk = 1'b0;
  logic rst, cmd_valid;
  logic [2:0] cmd;
  logic [DW-1:0] din;
  logic cmd_ready, done, empty, full, err;
  logic [DW-1:0] dvr;
  logic [AW-1:0] dar;

  stack_calc_core #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd(cmd),
    .din(din), .cmd_ready(cmd_ready), .done(done), .dvr(dvr),
    .dar(dar), .empty(empty), .full(full), .err(err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [7:0] m_mem [DEPTH];
  bit         m_vld [DEPTH];
  int         m_cnt, m_dar;
  logic [7:0] m_dvr;
  bit         m_err, m_ok;

  function automatic void model_reset();
    m_cnt = 0; m_dar = 0; m_dvr = 8'h00; m_err = 0; m_ok = 1;
  endfunction

  // Returns expected latency in edges after the accepting edge.
  function automatic int model(input logic [2:0] c, input logic [7:0] d);
    int top, sec, a;
    top = (DEPTH - m_cnt) % DEPTH;
    sec = (top + 1) % DEPTH;
    case (c)
      3'd0: begin
        if (m_cnt == DEPTH) begin m_err = 1; return 1; end
        a = DEPTH - 1 - m_cnt;
        m_mem[a] = d; m_vld[a] = 1;
        m_cnt++; m_dar = a; m_dvr = d; m_ok = 1;
        return 2;
      end
      3'd1: begin
        if (m_cnt < 1) begin m_err = 1; return 1; end
        m_cnt--;
        m_dar = (DEPTH - m_cnt) % DEPTH;
        m_dvr = (m_cnt == 0) ? 8'h00 : m_mem[m_dar];
        m_ok = (m_cnt == 0) || m_vld[m_dar];
        return 3;
      end
      3'd2, 3'd3: begin
        if (m_cnt < 2) begin m_err = 1; return 1; end
        if (c == 3'd2) m_dvr = m_mem[sec] + m_mem[top];
        else m_dvr = m_mem[sec] - m_mem[top];
        m_mem[sec] = m_dvr;
        m_cnt--; m_dar = sec; m_ok = 1;
        return 5;
      end
      3'd4: begin
        if (m_cnt == 0) begin
          m_dar = 0; m_dvr = 8'h00; m_ok = 1;
        end else begin
          m_dar = top; m_dvr = m_mem[top]; m_ok = m_vld[top];
        end
        return 3;
      end
      3'd5, 3'd6: begin
        if (c == 3'd5) m_dar = (m_dar + 1) % DEPTH;
        else m_dar = (m_dar + DEPTH - 1) % DEPTH;
        m_dvr = m_mem[m_dar]; m_ok = m_vld[m_dar];
        return 3;
      end
      default: begin
        model_reset();
        return 1;
      end
    endcase
  endfunction

  task automatic exec(input logic [2:0] c, input logic [7:0] d,
                      output int lat, output int elat);
    int guard;
    guard = 0;
    @(negedge clk);
    while (!cmd_ready && guard < 50) begin
      @(negedge clk); guard++;
    end
    if (!cmd_ready) begin
      checks++; errors++;
      $display("FAIL ready_timeout cmd=%0d got ready=%b exp 1", c, cmd_ready);
    end
    cmd_valid = 1'b1; cmd = c; din = d;
    elat = model(c, d);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    lat = 0;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      if (done) begin lat = k; break; end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; cmd_valid = 1'b0; cmd = 3'd0; din = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (cmd_ready !== 1'b0) begin
      errors++; $display("FAIL rst_ready got %b exp 0", cmd_ready);
    end
    rst = 1'b0;
    model_reset();
    for (int i = 0; i < DEPTH; i++) m_vld[i] = 0;
    #1;
    checks++;
    if (cmd_ready !== 1'b1 || done !== 1'b0 || err !== 1'b0) begin
      errors++;
      $display("FAIL rst_ctl got ready=%b done=%b err=%b exp 1 0 0",
               cmd_ready, done, err);
    end
    checks++;
    if (dvr !== 8'h00 || dar !== 7'h00 || empty !== 1'b1 || full !== 1'b0) begin
      errors++;
      $display("FAIL rst_data got dvr=%h dar=%h e=%b f=%b exp 00 00 1 0",
               dvr, dar, empty, full);
    end
  endtask

  task automatic test_push_sub();
    int l, el;
    exec(3'd7, 8'h00, l, el);
    exec(3'd0, 8'h05, l, el);
    checks++;
    if (l !== 2) begin errors++; $display("FAIL push_lat got %0d exp 2", l); end
    exec(3'd0, 8'h03, l, el);
    checks++;
    if (l !== 2 || dvr !== 8'h03 || dar !== 7'h7E) begin
      errors++;
      $display("FAIL push2 got lat=%0d dvr=%h dar=%h exp 2 03 7e", l, dvr, dar);
    end
    exec(3'd3, 8'h00, l, el);
    checks++;
    if (l !== 5 || dvr !== 8'h02 || dar !== 7'h7F || empty !== 1'b0) begin
      errors++;
      $display("FAIL sub got lat=%0d dvr=%h dar=%h e=%b exp 5 02 7f 0",
               l, dvr, dar, empty);
    end
    exec(3'd7, 8'h00, l, el);
    exec(3'd0, 8'h03, l, el);
    exec(3'd0, 8'h05, l, el);
    exec(3'd3, 8'h00, l, el);
    checks++;
    if (dvr !== 8'hFE || dar !== 7'h7F) begin
      errors++; $display("FAIL sub_wrap got dvr=%h dar=%h exp fe 7f", dvr, dar);
    end
  endtask

  task automatic test_errors();
    int l, el;
    exec(3'd7, 8'h00, l, el);
    exec(3'd1, 8'h00, l, el);
    checks++;
    if (l !== 1 || err !== 1'b1 || empty !== 1'b1) begin
      errors++;
      $display("FAIL pop_empty got lat=%0d err=%b e=%b exp 1 1 1", l, err, empty);
    end
    exec(3'd0, 8'h09, l, el);
    exec(3'd2, 8'h00, l, el);
    checks++;
    if (l !== 1 || err !== 1'b1 || dvr !== 8'h09 || dar !== 7'h7F || empty !== 1'b0) begin
      errors++;
      $display("FAIL add_one got lat=%0d err=%b dvr=%h dar=%h exp 1 1 09 7f",
               l, err, dvr, dar);
    end
    exec(3'd0, 8'h04, l, el);
    checks++;
    if (l !== 2 || err !== 1'b1 || dvr !== 8'h04) begin
      errors++;
      $display("FAIL push_after_err got lat=%0d err=%b dvr=%h exp 2 1 04", l, err, dvr);
    end
    exec(3'd7, 8'h00, l, el);
    checks++;
    if (l !== 1 || err !== 1'b0 || dvr !== 8'h00 || dar !== 7'h00) begin
      errors++;
      $display("FAIL clr got lat=%0d err=%b dvr=%h dar=%h exp 1 0 00 00",
               l, err, dvr, dar);
    end
  endtask

  task automatic test_full();
    int l, el;
    exec(3'd7, 8'h00, l, el);
    for (int i = 0; i < DEPTH; i++) exec(3'd0, 8'(i), l, el);
    checks++;
    if (full !== 1'b1) begin errors++; $display("FAIL full got %b exp 1", full); end
    exec(3'd0, 8'hAA, l, el);
    checks++;
    if (l !== 1 || err !== 1'b1 || dvr !== 8'd127 || dar !== 7'h00) begin
      errors++;
      $display("FAIL push_full got lat=%0d err=%b dvr=%h dar=%h exp 1 1 7f 00",
               l, err, dvr, dar);
    end
    exec(3'd1, 8'h00, l, el);
    checks++;
    if (l !== 3 || dvr !== 8'(DEPTH-2) || full !== 1'b0 || dar !== 7'h01) begin
      errors++;
      $display("FAIL pop_full got lat=%0d dvr=%h f=%b dar=%h exp 3 7e 0 01",
               l, dvr, full, dar);
    end
  endtask

  task automatic test_wrap();
    int l, el;
    exec(3'd7, 8'h00, l, el);
    exec(3'd6, 8'h00, l, el);
    checks++;
    if (l !== 3 || dar !== 7'h7F || dvr !== 8'h00) begin
      errors++;
      $display("FAIL dec_wrap got lat=%0d dar=%h dvr=%h exp 3 7f 00", l, dar, dvr);
    end
    exec(3'd5, 8'h00, l, el);
    checks++;
    if (dar !== 7'h00 || dvr !== 8'd127) begin
      errors++; $display("FAIL inc_wrap got dar=%h dvr=%h exp 00 7f", dar, dvr);
    end
  endtask

  task automatic test_busy_drop();
    int pulses, first;
    @(negedge clk);
    cmd_valid = 1'b1; cmd = 3'd5; din = 8'h00;
    void'(model(3'd5, 8'h00));
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    @(negedge clk);
    cmd_valid = 1'b1; cmd = 3'd7;
    @(negedge clk);
    cmd_valid = 1'b0;
    pulses = 0; first = 0;
    for (int k = 2; k <= 12; k++) begin
      @(posedge clk); #1;
      if (done) begin pulses++; if (first == 0) first = k; end
    end
    checks++;
    if (pulses !== 1 || first !== 3) begin
      errors++;
      $display("FAIL busy_drop got pulses=%0d at=%0d exp 1 3", pulses, first);
    end
    checks++;
    if (dar !== 7'(m_dar) || dvr !== m_dvr) begin
      errors++;
      $display("FAIL busy_state got dar=%h dvr=%h exp %h %h", dar, dvr, 7'(m_dar), m_dvr);
    end
  endtask

  task automatic test_reset_mid();
    int l, el, pulses;
    exec(3'd7, 8'h00, l, el);
    exec(3'd0, 8'h11, l, el);
    exec(3'd0, 8'h22, l, el);
    @(negedge clk);
    cmd_valid = 1'b1; cmd = 3'd2;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (done !== 1'b0 || cmd_ready !== 1'b0) begin
      errors++;
      $display("FAIL mid_rst got done=%b ready=%b exp 0 0", done, cmd_ready);
    end
    rst = 1'b0;
    model_reset();
    #1;
    checks++;
    if (cmd_ready !== 1'b1 || empty !== 1'b1 || dvr !== 8'h00) begin
      errors++;
      $display("FAIL post_rst got ready=%b e=%b dvr=%h exp 1 1 00",
               cmd_ready, empty, dvr);
    end
    pulses = 0;
    repeat (6) begin @(posedge clk); #1; if (done) pulses++; end
    checks++;
    if (pulses !== 0) begin errors++; $display("FAIL rst_no_done got %0d exp 0", pulses); end
    exec(3'd6, 8'h00, l, el);
    exec(3'd6, 8'h00, l, el);
    checks++;
    if (dar !== 7'h7E || dvr !== 8'h22) begin
      errors++; $display("FAIL rst_no_write got dar=%h dvr=%h exp 7e 22", dar, dvr);
    end
  endtask

  task automatic test_random();
    int l, el, r;
    logic [2:0] c;
    for (int n = 0; n < 300; n++) begin
      r = $urandom_range(99);
      if (r < 35) c = 3'd0;
      else if (r < 50) c = 3'd1;
      else if (r < 60) c = 3'd2;
      else if (r < 70) c = 3'd3;
      else if (r < 80) c = 3'd4;
      else if (r < 88) c = 3'd5;
      else if (r < 96) c = 3'd6;
      else c = 3'd7;
      exec(c, 8'($urandom), l, el);
      checks++;
      if (l !== el || dar !== 7'(m_dar) || err !== m_err
          || empty !== (m_cnt == 0) || full !== (m_cnt == DEPTH)
          || (m_ok && dvr !== m_dvr)) begin
        errors++;
        $display("FAIL rand%0d cmd=%0d got lat=%0d dar=%h dvr=%h err=%b e=%b f=%b exp %0d %h %h %b %b %b",
                 n, c, l, dar, dvr, err, empty, full, el, 7'(m_dar), m_dvr,
                 m_err, m_cnt == 0, m_cnt == DEPTH);
      end
    end
  endtask

  initial begin
    test_reset();
    test_push_sub();
    test_errors();
    test_full();
    test_wrap();
    test_busy_drop();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
